// File: rtl/rename_map_unit_pkg.sv
// Shared rename constants and helpers.
// Holds the default register-file geometry used by the rename map unit, the
// free list and the ROB preg ports.
package rename_map_unit_pkg;

  localparam int unsigned RM_ARCH_REGS  = 32;
  localparam int unsigned RM_PHYS_REGS  = 64;
  localparam int unsigned RM_PREG_WIDTH = 6;
  localparam int unsigned RM_FL_DEPTH   = RM_PHYS_REGS - RM_ARCH_REGS;
  localparam int unsigned RM_ARCH_WIDTH = 5;

  typedef logic [RM_ARCH_WIDTH-1:0] arch_idx_t;

  // Number of destinations a two-wide group consumes (0..2).
  function automatic logic [1:0] need_sum(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rename_map_unit_preg_free_list.sv
// Circular free list of physical registers.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pop_count             pregs taken by an accepted rename group (0..2)
//   push0/1, push0/1_preg commit-side frees, slot 0 written first
//   flush                 rewind head to the committed head
//   head_preg0/1          the next two free pregs (fl[head], fl[head+1])
//   free_count            occupancy, tail - head
// Every commit of a renamed destination pushes exactly one preg, so the
// committed head advances by the push count.
module preg_free_list #(
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned PHYS_REGS  = 64,
  parameter int unsigned FL_DEPTH   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                pop_count,
  input  logic                      push0,
  input  logic [PREG_WIDTH-1:0]     push0_preg,
  input  logic                      push1,
  input  logic [PREG_WIDTH-1:0]     push1_preg,
  input  logic                      flush,
  output logic [PREG_WIDTH-1:0]     head_preg0,
  output logic [PREG_WIDTH-1:0]     head_preg1,
  output logic [$clog2(FL_DEPTH):0] free_count
);

  localparam int unsigned IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [PREG_WIDTH-1:0] fl [FL_DEPTH];
  logic [PTR_W-1:0] head, tail, cmt_head;
  logic [PTR_W-1:0] head1, tail1, tail_next, cmt_head_next;

  assign head1         = head + PTR_W'(1);
  assign tail1         = tail + PTR_W'(push0);
  assign tail_next     = tail + PTR_W'(push0) + PTR_W'(push1);
  assign cmt_head_next = cmt_head + PTR_W'(push0) + PTR_W'(push1);

  assign head_preg0 = fl[head[IDX_W-1:0]];
  assign head_preg1 = fl[head1[IDX_W-1:0]];
  assign free_count = tail - head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FL_DEPTH; i++)
        fl[i] <= PREG_WIDTH'(PHYS_REGS - FL_DEPTH + i);
      head     <= '0;
      // Index 0 with the wrap bit set: full, not empty.
      tail     <= PTR_W'(FL_DEPTH);
      cmt_head <= '0;
    end else begin
      if (push0) fl[tail[IDX_W-1:0]]  <= push0_preg;
      if (push1) fl[tail1[IDX_W-1:0]] <= push1_preg;
      tail     <= tail_next;
      cmt_head <= cmt_head_next;
      head     <= flush ? cmt_head_next : head + PTR_W'(pop_count);
    end
  end

  logic [OCC_W-1:0] occ_after_push, occ_limit;
  assign occ_after_push = {1'b0, free_count} + OCC_W'(push0) + OCC_W'(push1);
  assign occ_limit      = OCC_W'(FL_DEPTH) + OCC_W'(pop_count);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    occ_after_push <= occ_limit);

endmodule

// File: rtl/rename_map_unit.sv
// Two-wide register rename for one register class.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rnK_valid/has_dest/rs1/rs2/rd   rename slot K inputs
//   rnK_prs1/prs2/new_preg/old_preg renamed outputs (combinational)
//   rn_ready, rn_fire               group handshake
//   cmK_*                           ROB commit slot K
//   flush                           restore speculative map from committed map
//   free_count                      free-list occupancy
module rename_map_unit import rename_map_unit_pkg::*; #(
  parameter int unsigned ARCH_REGS      = RM_ARCH_REGS,
  parameter int unsigned PHYS_REGS      = RM_PHYS_REGS,
  parameter int unsigned PREG_WIDTH     = RM_PREG_WIDTH,
  parameter int unsigned FL_DEPTH       = RM_FL_DEPTH,
  parameter int unsigned ZERO_HARDWIRED = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rn0_valid,
  input  logic                      rn0_has_dest,
  input  arch_idx_t                 rn0_rs1,
  input  arch_idx_t                 rn0_rs2,
  input  arch_idx_t                 rn0_rd,
  input  logic                      rn1_valid,
  input  logic                      rn1_has_dest,
  input  arch_idx_t                 rn1_rs1,
  input  arch_idx_t                 rn1_rs2,
  input  arch_idx_t                 rn1_rd,
  output logic [PREG_WIDTH-1:0]     rn0_prs1,
  output logic [PREG_WIDTH-1:0]     rn0_prs2,
  output logic [PREG_WIDTH-1:0]     rn0_new_preg,
  output logic [PREG_WIDTH-1:0]     rn0_old_preg,
  output logic [PREG_WIDTH-1:0]     rn1_prs1,
  output logic [PREG_WIDTH-1:0]     rn1_prs2,
  output logic [PREG_WIDTH-1:0]     rn1_new_preg,
  output logic [PREG_WIDTH-1:0]     rn1_old_preg,
  output logic                      rn_ready,
  input  logic                      rn_fire,
  input  logic                      cm0_valid,
  input  logic                      cm0_has_dest,
  input  logic                      cm0_exception,
  input  arch_idx_t                 cm0_arch_rd,
  input  logic [PREG_WIDTH-1:0]     cm0_new_preg,
  input  logic [PREG_WIDTH-1:0]     cm0_old_preg,
  input  logic                      cm1_valid,
  input  logic                      cm1_has_dest,
  input  logic                      cm1_exception,
  input  arch_idx_t                 cm1_arch_rd,
  input  logic [PREG_WIDTH-1:0]     cm1_new_preg,
  input  logic [PREG_WIDTH-1:0]     cm1_old_preg,
  input  logic                      flush,
  output logic [$clog2(FL_DEPTH):0] free_count
);

  localparam int unsigned CNT_W = $clog2(FL_DEPTH) + 1;
  localparam logic ZH = (ZERO_HARDWIRED != 0);

  logic [PREG_WIDTH-1:0] spec_rat [ARCH_REGS];
  logic [PREG_WIDTH-1:0] arch_rat [ARCH_REGS];
  logic [PREG_WIDTH-1:0] arch_next [ARCH_REGS];

  logic       need0, need1, fire_ok;
  logic [1:0] need_n, pop_count;
  logic [PREG_WIDTH-1:0] head_preg0, head_preg1;
  logic       cm_do0, cm_do1;

  assign need0  = rn0_valid & rn0_has_dest & ~(ZH & (rn0_rd == '0));
  assign need1  = rn1_valid & rn1_has_dest & ~(ZH & (rn1_rd == '0));
  assign need_n = need_sum(need0, need1);

  assign rn_ready  = free_count >= CNT_W'(need_n);
  assign fire_ok   = rn_fire & rn_ready & ~flush;
  assign pop_count = fire_ok ? need_n : 2'd0;

  // Source lookup; slot 1 sees slot 0's fresh destination.
  assign rn0_prs1 = (ZH && rn0_rs1 == '0) ? '0 : spec_rat[rn0_rs1];
  assign rn0_prs2 = (ZH && rn0_rs2 == '0) ? '0 : spec_rat[rn0_rs2];
  assign rn1_prs1 = (need0 && rn1_rs1 == rn0_rd) ? rn0_new_preg :
                    (ZH && rn1_rs1 == '0) ? '0 : spec_rat[rn1_rs1];
  assign rn1_prs2 = (need0 && rn1_rs2 == rn0_rd) ? rn0_new_preg :
                    (ZH && rn1_rs2 == '0) ? '0 : spec_rat[rn1_rs2];

  assign rn0_new_preg = need0 ? head_preg0 : '0;
  assign rn1_new_preg = need1 ? (need0 ? head_preg1 : head_preg0) : '0;
  assign rn0_old_preg = need0 ? spec_rat[rn0_rd] : '0;
  assign rn1_old_preg = need1 ? ((need0 && rn1_rd == rn0_rd) ? rn0_new_preg
                                                             : spec_rat[rn1_rd]) : '0;

  assign cm_do0 = cm0_valid & cm0_has_dest & ~(ZH & (cm0_arch_rd == '0));
  assign cm_do1 = cm1_valid & cm1_has_dest & ~(ZH & (cm1_arch_rd == '0));

  // Committed map including this cycle's commits; flush copies it so the
  // restored speculative map is never one commit behind.
  always_comb begin
    arch_next = arch_rat;
    if (cm_do0 && !cm0_exception) arch_next[cm0_arch_rd] = cm0_new_preg;
    if (cm_do1 && !cm1_exception) arch_next[cm1_arch_rd] = cm1_new_preg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_rat[i] <= PREG_WIDTH'(i);
        arch_rat[i] <= PREG_WIDTH'(i);
      end
    end else begin
      arch_rat <= arch_next;
      if (flush) begin
        spec_rat <= arch_next;
      end else if (fire_ok) begin
        if (need0) spec_rat[rn0_rd] <= rn0_new_preg;
        if (need1) spec_rat[rn1_rd] <= rn1_new_preg;
      end
    end
  end

  preg_free_list #(
    .PREG_WIDTH (PREG_WIDTH),
    .PHYS_REGS  (PHYS_REGS),
    .FL_DEPTH   (FL_DEPTH)
  ) u_free_list (
    .clk        (clk),
    .rst_n      (rst_n),
    .pop_count  (pop_count),
    .push0      (cm_do0),
    .push0_preg (cm0_exception ? cm0_new_preg : cm0_old_preg),
    .push1      (cm_do1),
    .push1_preg (cm1_exception ? cm1_new_preg : cm1_old_preg),
    .flush      (flush),
    .head_preg0 (head_preg0),
    .head_preg1 (head_preg1),
    .free_count (free_count)
  );

endmodule

// File: tb/tb_rename_map_unit.sv
// Self-checking bench for rename_map_unit (integer class, x0 hardwired).
// Directed scenarios followed by a randomized phase; the bench plays the ROB
// and keeps a queue-based reference model of maps and free pregs.
module tb_rename_map_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       rn0_valid, rn0_has_dest, rn1_valid, rn1_has_dest, rn_fire, flush;
  logic [4:0] rn0_rs1, rn0_rs2, rn0_rd, rn1_rs1, rn1_rs2, rn1_rd;
  logic [5:0] rn0_prs1, rn0_prs2, rn0_new_preg, rn0_old_preg;
  logic [5:0] rn1_prs1, rn1_prs2, rn1_new_preg, rn1_old_preg;
  logic       rn_ready;
  logic       cm0_valid, cm0_has_dest, cm0_exception, cm1_valid, cm1_has_dest, cm1_exception;
  logic [4:0] cm0_arch_rd, cm1_arch_rd;
  logic [5:0] cm0_new_preg, cm0_old_preg, cm1_new_preg, cm1_old_preg;
  logic [5:0] free_count;

  rename_map_unit #(
    .ARCH_REGS(32), .PHYS_REGS(64), .PREG_WIDTH(6), .FL_DEPTH(32), .ZERO_HARDWIRED(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rn0_valid(rn0_valid), .rn0_has_dest(rn0_has_dest),
    .rn0_rs1(rn0_rs1), .rn0_rs2(rn0_rs2), .rn0_rd(rn0_rd),
    .rn1_valid(rn1_valid), .rn1_has_dest(rn1_has_dest),
    .rn1_rs1(rn1_rs1), .rn1_rs2(rn1_rs2), .rn1_rd(rn1_rd),
    .rn0_prs1(rn0_prs1), .rn0_prs2(rn0_prs2), .rn0_new_preg(rn0_new_preg), .rn0_old_preg(rn0_old_preg),
    .rn1_prs1(rn1_prs1), .rn1_prs2(rn1_prs2), .rn1_new_preg(rn1_new_preg), .rn1_old_preg(rn1_old_preg),
    .rn_ready(rn_ready), .rn_fire(rn_fire),
    .cm0_valid(cm0_valid), .cm0_has_dest(cm0_has_dest), .cm0_exception(cm0_exception),
    .cm0_arch_rd(cm0_arch_rd), .cm0_new_preg(cm0_new_preg), .cm0_old_preg(cm0_old_preg),
    .cm1_valid(cm1_valid), .cm1_has_dest(cm1_has_dest), .cm1_exception(cm1_exception),
    .cm1_arch_rd(cm1_arch_rd), .cm1_new_preg(cm1_new_preg), .cm1_old_preg(cm1_old_preg),
    .flush(flush), .free_count(free_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: maps as arrays, free pregs as an ordered queue,
  // allocated-but-uncommitted pregs in allocation order, and the ROB.
  typedef struct { int rd; int np; int op; } rob_t;
  int   spec_m [32];
  int   arch_m [32];
  int   fq[$];
  int   infl[$];
  rob_t rob[$];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin spec_m[i] = i; arch_m[i] = i; end
    fq.delete(); infl.delete(); rob.delete();
    for (int i = 32; i < 64; i++) fq.push_back(i);
  endtask

  task automatic idle();
    rn0_valid = 0; rn0_has_dest = 0; rn0_rs1 = 0; rn0_rs2 = 0; rn0_rd = 0;
    rn1_valid = 0; rn1_has_dest = 0; rn1_rs1 = 0; rn1_rs2 = 0; rn1_rd = 0;
    rn_fire = 0; flush = 0;
    cm0_valid = 0; cm0_has_dest = 0; cm0_exception = 0; cm0_arch_rd = 0; cm0_new_preg = 0; cm0_old_preg = 0;
    cm1_valid = 0; cm1_has_dest = 0; cm1_exception = 0; cm1_arch_rd = 0; cm1_new_preg = 0; cm1_old_preg = 0;
  endtask

  task automatic set_rn(input int k, input bit v, input bit hd, input int rs1, input int rs2, input int rd);
    if (k == 0) begin
      rn0_valid = v; rn0_has_dest = hd; rn0_rs1 = 5'(rs1); rn0_rs2 = 5'(rs2); rn0_rd = 5'(rd);
    end else begin
      rn1_valid = v; rn1_has_dest = hd; rn1_rs1 = 5'(rs1); rn1_rs2 = 5'(rs2); rn1_rd = 5'(rd);
    end
  endtask

  task automatic set_cm(input int k, input bit v, input bit hd, input bit ex, input int rd, input int np, input int op);
    if (k == 0) begin
      cm0_valid = v; cm0_has_dest = hd; cm0_exception = ex; cm0_arch_rd = 5'(rd);
      cm0_new_preg = 6'(np); cm0_old_preg = 6'(op);
    end else begin
      cm1_valid = v; cm1_has_dest = hd; cm1_exception = ex; cm1_arch_rd = 5'(rd);
      cm1_new_preg = 6'(np); cm1_old_preg = 6'(op);
    end
  endtask

  function automatic int look(input int r);
    return (r == 0) ? 0 : spec_m[r];
  endfunction

  // Called at a negedge with inputs set: checks combinational outputs,
  // clocks once, advances the model, returns at the next negedge.
  task automatic cycle();
    int n0, n1, e_new0, e_new1, e_old0, e_old1, e;
    bit ready;
    bit cv[2], chd[2], cex[2];
    int crd[2], cnp[2], cop[2];
    int pushes[$];
    #1;
    n0 = (rn0_valid && rn0_has_dest && rn0_rd != 0) ? 1 : 0;
    n1 = (rn1_valid && rn1_has_dest && rn1_rd != 0) ? 1 : 0;
    ready  = fq.size() >= n0 + n1;
    e_new0 = (n0 != 0 && fq.size() > 0) ? fq[0] : 0;
    e_new1 = (n1 != 0 && fq.size() > n0) ? fq[n0] : 0;
    e_old0 = (n0 != 0) ? spec_m[rn0_rd] : 0;
    e_old1 = (n1 != 0) ? ((n0 != 0 && rn1_rd == rn0_rd) ? e_new0 : spec_m[rn1_rd]) : 0;
    check("free_count", free_count, fq.size());
    check("rn_ready", rn_ready, ready);
    check("rn0_prs1", rn0_prs1, look(rn0_rs1));
    check("rn0_prs2", rn0_prs2, look(rn0_rs2));
    check("rn1_prs1", rn1_prs1, (n0 != 0 && rn1_rs1 == rn0_rd) ? e_new0 : look(rn1_rs1));
    check("rn1_prs2", rn1_prs2, (n0 != 0 && rn1_rs2 == rn0_rd) ? e_new0 : look(rn1_rs2));
    check("rn0_old", rn0_old_preg, e_old0);
    check("rn1_old", rn1_old_preg, e_old1);
    if (ready) begin
      check("rn0_new", rn0_new_preg, e_new0);
      check("rn1_new", rn1_new_preg, e_new1);
    end
    @(posedge clk);
    cv[0] = cm0_valid; chd[0] = cm0_has_dest; cex[0] = cm0_exception;
    crd[0] = cm0_arch_rd; cnp[0] = cm0_new_preg; cop[0] = cm0_old_preg;
    cv[1] = cm1_valid; chd[1] = cm1_has_dest; cex[1] = cm1_exception;
    crd[1] = cm1_arch_rd; cnp[1] = cm1_new_preg; cop[1] = cm1_old_preg;
    for (int k = 0; k < 2; k++) begin
      if (cv[k] && chd[k] && crd[k] != 0) begin
        if (!cex[k]) arch_m[crd[k]] = cnp[k];
        pushes.push_back(cex[k] ? cnp[k] : cop[k]);
        if (infl.size() > 0) e = infl.pop_front();
      end
    end
    if (flush) begin
      spec_m = arch_m;
      fq = {infl, fq, pushes};
      infl.delete();
      rob.delete();
    end else begin
      if (rn_fire && ready) begin
        if (n0 != 0) begin
          e = fq.pop_front(); infl.push_back(e);
          spec_m[rn0_rd] = e_new0;
          rob.push_back('{int'(rn0_rd), e_new0, e_old0});
        end
        if (n1 != 0) begin
          e = fq.pop_front(); infl.push_back(e);
          spec_m[rn1_rd] = e_new1;
          rob.push_back('{int'(rn1_rd), e_new1, e_old1});
        end
      end
      foreach (pushes[i]) fq.push_back(pushes[i]);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a negedge.
  task automatic do_reset();
    idle();
    rn0_rs1 = 5'd17;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_free_count", free_count, 32);
    check("reset_rn0_prs1", rn0_prs1, 17);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rob_t r;
    int ncm;
    rst_n = 1'b1;
    idle();
    @(negedge clk);

    // Basic two-wide rename with intra-group bypass.
    do_reset();
    set_rn(0, 1, 1, 0, 0, 5); set_rn(1, 1, 1, 5, 0, 6); rn_fire = 1;
    #1;
    check("t1_rn0_new", rn0_new_preg, 32);
    check("t1_rn0_old", rn0_old_preg, 5);
    check("t1_rn1_prs1", rn1_prs1, 32);
    check("t1_rn1_new", rn1_new_preg, 33);
    check("t1_rn1_old", rn1_old_preg, 6);
    cycle();
    idle(); #1;
    check("t1_free_count", free_count, 30);
    cycle();

    // Same rd in both slots.
    do_reset();
    set_rn(0, 1, 1, 0, 0, 7); set_rn(1, 1, 1, 0, 0, 7); rn_fire = 1;
    #1;
    check("t2_rn1_old", rn1_old_preg, 32);
    check("t2_rn1_new", rn1_new_preg, 33);
    cycle();
    idle(); set_rn(0, 1, 0, 7, 0, 0); #1;
    check("t2_rs1_after", rn0_prs1, 33);
    cycle();

    // Fill the free list, then free one preg by commit.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      idle();
      set_rn(0, 1, 1, c, c + 1, ((2 * c + 4) % 31) + 1);
      set_rn(1, 1, 1, c + 2, c + 3, ((2 * c + 5) % 31) + 1);
      rn_fire = 1;
      cycle();
    end
    idle(); set_rn(0, 1, 1, 0, 0, 3); #1;
    check("t3_full_count", free_count, 0);
    check("t3_not_ready", rn_ready, 0);
    idle(); set_rn(0, 1, 0, 0, 0, 3); set_rn(1, 1, 1, 0, 0, 0); rn_fire = 1; #1;
    check("t3_ready_nodest", rn_ready, 1);
    cycle();
    idle(); set_cm(0, 1, 1, 0, 5, 32, 5);
    cycle();
    idle(); set_rn(0, 1, 1, 0, 0, 9); rn_fire = 1; #1;
    check("t3_realloc_5", rn0_new_preg, 5);
    cycle();
    idle(); flush = 1;
    cycle();
    idle(); set_rn(0, 1, 0, 5, 6, 0); #1;
    check("t3_arch5", rn0_prs1, 32);
    check("t3_arch6", rn0_prs2, 6);
    cycle();

    // Commit one of four, then flush.
    do_reset();
    set_rn(0, 1, 1, 0, 0, 1); set_rn(1, 1, 1, 0, 0, 2); rn_fire = 1; cycle();
    set_rn(0, 1, 1, 0, 0, 3); set_rn(1, 1, 1, 0, 0, 4); rn_fire = 1; cycle();
    idle(); set_cm(0, 1, 1, 0, 1, 32, 1); cycle();
    idle(); flush = 1; cycle();
    idle(); set_rn(0, 1, 1, 1, 2, 8); set_rn(1, 1, 0, 3, 0, 0); rn_fire = 1; #1;
    check("t4_prs_r1", rn0_prs1, 32);
    check("t4_prs_r2", rn0_prs2, 2);
    check("t4_prs_r3", rn1_prs1, 3);
    check("t4_next_alloc", rn0_new_preg, 33);
    cycle();

    // Exception commit together with flush and an ignored rename.
    do_reset();
    set_rn(0, 1, 1, 0, 0, 1); set_rn(1, 1, 1, 0, 0, 2); rn_fire = 1; cycle();
    set_rn(0, 1, 1, 0, 0, 3); set_rn(1, 1, 1, 0, 0, 4); rn_fire = 1; cycle();
    idle(); set_cm(0, 1, 1, 0, 1, 32, 1); set_cm(1, 1, 1, 0, 2, 33, 2); cycle();
    idle(); set_cm(0, 1, 1, 1, 3, 34, 3); flush = 1;
    set_rn(0, 1, 1, 0, 0, 10); rn_fire = 1;
    cycle();
    idle(); set_rn(0, 1, 1, 3, 10, 11); rn_fire = 1; #1;
    check("t5_arch3", rn0_prs1, 3);
    check("t5_rd10", rn0_prs2, 10);
    check("t5_next_alloc", rn0_new_preg, 35);
    cycle();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      set_rn(0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      set_rn(1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      rn_fire = ($urandom_range(0, 4) != 0);
      ncm = $urandom_range(0, 2);
      if (ncm > rob.size()) ncm = rob.size();
      for (int k = 0; k < ncm; k++) begin
        r = rob.pop_front();
        if ($urandom_range(0, 19) == 0) begin
          set_cm(k, 1, 1, 1, r.rd, r.np, r.op);
          flush = 1;
          break;
        end
        set_cm(k, 1, 1, 0, r.rd, r.np, r.op);
      end
      if (!cm1_valid && !cm1_exception && !cm0_exception && $urandom_range(0, 9) == 0)
        set_cm(1, 1, 1, 0, 0, $urandom_range(0, 63), $urandom_range(0, 63));
      if ($urandom_range(0, 32) == 0) flush = 1;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
